// File: rtl/graph_pkg.sv
// Shared types for the day-11 graph pipeline: node id type and walk FSM states.
package graph_pkg;

   localparam int unsigned DEFAULT_MAX_NODES  = 1024;
   localparam int unsigned DEFAULT_NODE_WIDTH = $clog2(DEFAULT_MAX_NODES);

   typedef logic [DEFAULT_NODE_WIDTH-1:0] node_t;

   typedef enum logic [2:0] {
      StIdle,
      StPop,
      StCheck,
      StQuery,
      StRecv,
      StDone
   } path_counter_state_t;

   // True while a walk is in flight (drives the busy output).
   function automatic logic is_walking(input path_counter_state_t st);
      return (st == StPop) || (st == StCheck) || (st == StQuery) || (st == StRecv);
   endfunction

endpackage

// File: rtl/path_counter_if.sv
// Query/reply channel between the path counter (master) and the adjacency-map responder (slave).
interface path_counter_if
   import graph_pkg::*;
#(
   parameter int unsigned NODE_WIDTH = DEFAULT_NODE_WIDTH
) ();

   logic                  query_valid;
   logic                  query_ready;
   logic [NODE_WIDTH-1:0] query_data;
   logic                  reply_valid;
   logic                  reply_ready;
   logic [NODE_WIDTH-1:0] reply_data;
   logic                  reply_last;
   logic                  reply_no_edges_found;

   modport master (
      output query_valid,
      output query_data,
      output reply_ready,
      input  query_ready,
      input  reply_valid,
      input  reply_data,
      input  reply_last,
      input  reply_no_edges_found
   );

   modport slave (
      input  query_valid,
      input  query_data,
      input  reply_ready,
      output query_ready,
      output reply_valid,
      output reply_data,
      output reply_last,
      output reply_no_edges_found
   );

endinterface

// File: rtl/node_stack.sv
// Synchronous LIFO of pending node ids. Pushes into a full stack are dropped;
// the caller sees full_o and decides what to flag. Entry storage is not reset.
module node_stack #(
   parameter int unsigned DEPTH = 512,
   parameter int unsigned WIDTH = 10,
   localparam int unsigned ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned LEVEL_W = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push_i,
   input  logic [WIDTH-1:0]   push_data_i,
   input  logic               pop_i,
   output logic [WIDTH-1:0]   top_o,
   output logic               empty_o,
   output logic               full_o,
   output logic [LEVEL_W-1:0] level_o
);

   logic [WIDTH-1:0]   mem_q [DEPTH];
   logic [LEVEL_W-1:0] ptr_q, ptr_d;
   logic               push_ok;
   logic               pop_ok;
   logic [ADDR_W-1:0]  wr_idx;
   logic [ADDR_W-1:0]  top_idx;

   assign empty_o = (ptr_q == '0);
   assign full_o  = (ptr_q == LEVEL_W'(DEPTH));
   assign level_o = ptr_q;
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign wr_idx  = ADDR_W'(ptr_q);
   assign top_idx = ADDR_W'(ptr_q - LEVEL_W'(1));
   assign top_o   = mem_q[top_idx];

   // Pointer update: push grows, pop shrinks, dropped push leaves it alone
   always_comb begin
      ptr_d = ptr_q;
      if (push_ok) begin
         ptr_d = ptr_q + LEVEL_W'(1);
      end else if (pop_ok) begin
         ptr_d = ptr_q - LEVEL_W'(1);
      end
   end

   // Occupancy pointer register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // Entry storage write port
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_idx] <= push_data_i;
      end
   end

endmodule

// File: rtl/path_counter.sv
// Depth-first path counter over the adjacency-map responder.
// Optional build macro PATH_COUNTER_STATS_EN adds query_count and max_stack_level outputs.
module path_counter
   import graph_pkg::*;
#(
   parameter int unsigned MAX_NODES   = 1024,
   parameter int unsigned NODE_WIDTH  = $clog2(MAX_NODES),
   parameter int unsigned STACK_DEPTH = 512,
   parameter int unsigned COUNT_WIDTH = 48,
   localparam int unsigned LEVEL_WIDTH = $clog2(STACK_DEPTH) + 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [NODE_WIDTH-1:0]  start_node,
   input  logic [NODE_WIDTH-1:0]  target_node,
   path_counter_if.master         bus,
   output logic                   busy,
   output logic                   done,
   output logic [COUNT_WIDTH-1:0] path_count,
   output logic                   stack_overflow
`ifdef PATH_COUNTER_STATS_EN
   ,
   output logic [31:0]            query_count,
   output logic [LEVEL_WIDTH-1:0] max_stack_level
`endif
);

   path_counter_state_t state_q, state_d;

   logic [NODE_WIDTH-1:0]  target_q, target_d;
   logic [NODE_WIDTH-1:0]  cur_q, cur_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   done_q, done_d;
   logic                   ovf_q, ovf_d;
   logic                   first_q, first_d;

   logic                   idle_start;
   logic                   query_hs;
   logic                   beat;
   logic                   drop_beat;
   logic                   reply_end;
   logic                   is_target;

   logic                   stk_push;
   logic [NODE_WIDTH-1:0]  stk_push_data;
   logic                   stk_pop;
   logic [NODE_WIDTH-1:0]  stk_top;
   logic                   stk_empty;
   logic                   stk_full;
   logic [LEVEL_WIDTH-1:0] stk_level;

   assign idle_start = (state_q == StIdle) && start;
   assign query_hs   = (state_q == StQuery) && bus.query_ready;
   assign beat       = (state_q == StRecv) && bus.reply_valid;
   // A no-edges reply is a single beat whose data carries no successor
   assign drop_beat  = first_q && bus.reply_no_edges_found;
   assign reply_end  = beat && (drop_beat || bus.reply_last);
   assign is_target  = (cur_q == target_q);

   assign stk_push      = idle_start || (beat && !drop_beat);
   assign stk_push_data = idle_start ? start_node : bus.reply_data;
   assign stk_pop       = (state_q == StPop) && !stk_empty;

   node_stack #(
      .DEPTH (STACK_DEPTH),
      .WIDTH (NODE_WIDTH)
   ) u_stack (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (stk_push),
      .push_data_i (stk_push_data),
      .pop_i       (stk_pop),
      .top_o       (stk_top),
      .empty_o     (stk_empty),
      .full_o      (stk_full),
      .level_o     (stk_level)
   );

   // Walk state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Walk sequencing: pop, test for target, query, drain reply, repeat until empty
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StPop;
         StPop:   state_d = stk_empty ? StDone : StCheck;
         StCheck: state_d = is_target ? StPop : StQuery;
         StQuery: if (bus.query_ready) state_d = StRecv;
         StRecv:  if (reply_end) state_d = StPop;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Handshake and status outputs decoded from the state
   always_comb begin
      bus.query_valid = 1'b0;
      bus.reply_ready = 1'b0;
      busy            = is_walking(state_q);
      unique case (state_q)
         StQuery: bus.query_valid = 1'b1;
         StRecv:  bus.reply_ready = 1'b1;
         default: ;
      endcase
   end

   // Datapath next-state: target latch, current node, count and sticky flags
   always_comb begin
      target_d = target_q;
      cur_d    = cur_q;
      count_d  = count_q;
      done_d   = done_q;
      ovf_d    = ovf_q;
      first_d  = first_q;
      if (idle_start) begin
         target_d = target_node;
         count_d  = '0;
         done_d   = 1'b0;
         ovf_d    = 1'b0;
      end
      if (stk_push && stk_full) begin
         ovf_d = 1'b1;
      end
      if (stk_pop) begin
         cur_d = stk_top;
      end
      if ((state_q == StPop) && stk_empty) begin
         done_d = 1'b1;
      end
      if ((state_q == StCheck) && is_target) begin
         count_d = count_q + COUNT_WIDTH'(1);
      end
      if (query_hs) begin
         first_d = 1'b1;
      end else if (beat) begin
         first_d = 1'b0;
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         target_q <= '0;
         cur_q    <= '0;
         count_q  <= '0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         first_q  <= 1'b0;
      end else begin
         target_q <= target_d;
         cur_q    <= cur_d;
         count_q  <= count_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
         first_q  <= first_d;
      end
   end

   // cur_q only changes in POP, so query_data holds steady through a stalled QUERY
   assign bus.query_data = cur_q;
   assign done           = done_q;
   assign path_count     = count_q;
   assign stack_overflow = ovf_q;

`ifdef PATH_COUNTER_STATS_EN
   logic [31:0]            qcnt_q, qcnt_d;
   logic [LEVEL_WIDTH-1:0] maxlvl_q, maxlvl_d;

   // Statistics next-state: both clear on an accepted start
   always_comb begin
      qcnt_d   = qcnt_q;
      maxlvl_d = maxlvl_q;
      if (idle_start) begin
         qcnt_d   = '0;
         maxlvl_d = '0;
      end else begin
         if (query_hs) qcnt_d = qcnt_q + 32'd1;
         if (stk_level > maxlvl_q) maxlvl_d = stk_level;
      end
   end

   // Statistics registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qcnt_q   <= '0;
         maxlvl_q <= '0;
      end else begin
         qcnt_q   <= qcnt_d;
         maxlvl_q <= maxlvl_d;
      end
   end

   assign query_count     = qcnt_q;
   assign max_stack_level = maxlvl_q;
`else
   logic [LEVEL_WIDTH-1:0] unused_level;
   assign unused_level = stk_level;
`endif

endmodule

// File: tb/tb_path_counter.sv
// Randomized self-checking bench for path_counter against a DFS reference model.
module tb_path_counter;
   import graph_pkg::*;

   localparam int unsigned NODE_W  = 4;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned CNT_W   = 48;
   localparam int unsigned LVL_W   = $clog2(DEPTH) + 1;
   localparam int          NNODES  = 16;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [NODE_W-1:0] start_node;
   logic [NODE_W-1:0] target_node;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] path_count;
   logic             stack_overflow;
`ifdef PATH_COUNTER_STATS_EN
   logic [31:0]      query_count;
   logic [LVL_W-1:0] max_stack_level;
`endif

   path_counter_if #(.NODE_WIDTH(NODE_W)) bus ();

   path_counter #(
      .MAX_NODES   (NNODES),
      .NODE_WIDTH  (NODE_W),
      .STACK_DEPTH (DEPTH),
      .COUNT_WIDTH (CNT_W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .start_node     (start_node),
      .target_node    (target_node),
      .bus            (bus),
      .busy           (busy),
      .done           (done),
      .path_count     (path_count),
      .stack_overflow (stack_overflow)
`ifdef PATH_COUNTER_STATS_EN
      ,
      .query_count     (query_count),
      .max_stack_level (max_stack_level)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard state
   int     vectors = 0;
   int     miscompares = 0;
   int     adj [NNODES][$];
   longint exp_cnt;
   bit     exp_ovf;
   int     exp_nq;
   int     exp_max;
   int     exp_q [$];
   int     nq_seen;
   bit     armed = 0;
   bit     stall_mode = 0;

   function automatic void chk(input string nm, input longint act, input longint req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
      end
   endfunction

   // Reference: plain DFS with a bounded LIFO; pushes into a full stack are lost
   task automatic model_walk(input int s, input int t);
      int stk [$];
      int n;
      exp_cnt = 0; exp_ovf = 0; exp_nq = 0; exp_max = 1;
      exp_q.delete();
      stk.push_back(s);
      while (stk.size() > 0) begin
         n = stk.pop_back();
         if (n == t) begin
            exp_cnt++;
         end else begin
            exp_q.push_back(n);
            exp_nq++;
            for (int k = 0; k < adj[n].size(); k++) begin
               if (stk.size() >= DEPTH) exp_ovf = 1;
               else begin
                  stk.push_back(adj[n][k]);
                  if (stk.size() > exp_max) exp_max = stk.size();
               end
            end
         end
      end
   endtask

   task automatic clear_graph();
      for (int i = 0; i < NNODES; i++) adj[i].delete();
   endtask

   task automatic diamond();
      clear_graph();
      adj[0].push_back(1); adj[0].push_back(2);
      adj[1].push_back(3);
      adj[2].push_back(3);
   endtask

   // Responder model: one pending reply queued per accepted query
   typedef struct packed {
      logic [NODE_W-1:0] d;
      logic              last;
      logic              ne;
   } beat_t;

   beat_t rq [$];

   initial begin
      bit hs, bt;
      int qn, qv_wait, gcnt, lat;
      bit present;
      beat_t b;
      qv_wait = 0; gcnt = 0; lat = 0;
      bus.query_ready = 1'b0;
      bus.reply_valid = 1'b0;
      bus.reply_data = '0;
      bus.reply_last = 1'b0;
      bus.reply_no_edges_found = 1'b0;
      forever begin
         @(negedge clk);
         hs = bus.query_valid && bus.query_ready;
         bt = bus.reply_valid && bus.reply_ready;
         qn = int'(bus.query_data);
         if (hs || !bus.query_valid) qv_wait = 0;
         else qv_wait++;
         @(posedge clk);
         #1;
         if (!rst_n) begin
            rq.delete();
            lat = 0;
         end else begin
            if (bt && rq.size() > 0) void'(rq.pop_front());
            if (hs) begin
               if (adj[qn].size() == 0) begin
                  b.d = NODE_W'($urandom); b.last = 1'($urandom); b.ne = 1'b1;
                  rq.push_back(b);
               end else begin
                  for (int k = 0; k < adj[qn].size(); k++) begin
                     b.d = NODE_W'(adj[qn][k]);
                     b.last = (k == adj[qn].size() - 1);
                     b.ne = 1'b0;
                     rq.push_back(b);
                  end
               end
               lat = $urandom_range(0, 2);
            end
         end
         gcnt++;
         if (stall_mode) begin
            bus.query_ready = (qv_wait >= 10);
            present = (rq.size() > 0) && (gcnt % 4 == 3);
         end else begin
            bus.query_ready = ($urandom_range(0, 3) != 0);
            present = (rq.size() > 0) && (lat == 0) && ($urandom_range(0, 3) != 0);
         end
         if (lat > 0) lat--;
         bus.reply_valid = present;
         if (present) begin
            bus.reply_data = rq[0].d;
            bus.reply_last = rq[0].last;
            bus.reply_no_edges_found = rq[0].ne;
         end else begin
            bus.reply_data = '0;
            bus.reply_last = 1'b0;
            bus.reply_no_edges_found = 1'b0;
         end
      end
   end

   // Per-cycle compare process
   initial begin
      bit prev_stall;
      logic [NODE_W-1:0] prev_qd;
      prev_stall = 0;
      prev_qd = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_query_valid", bus.query_valid, 0);
            chk("rst_reply_ready", bus.reply_ready, 0);
            chk("rst_query_data", bus.query_data, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_path_count", path_count, 0);
            chk("rst_overflow", stack_overflow, 0);
`ifdef PATH_COUNTER_STATS_EN
            chk("rst_query_count", query_count, 0);
            chk("rst_max_level", max_stack_level, 0);
`endif
            prev_stall = 0;
         end else begin
            if (prev_stall) begin
               chk("query_valid_held", bus.query_valid, 1);
               chk("query_data_stable", bus.query_data, prev_qd);
            end
            prev_stall = bus.query_valid && !bus.query_ready;
            prev_qd = bus.query_data;
            if (bus.query_valid && bus.query_ready) begin
               nq_seen++;
               if (exp_q.size() == 0) chk("query_unexpected", 1, 0);
               else chk("query_node", bus.query_data, exp_q.pop_front());
            end
            if (armed && done) begin
               chk("done_path_count", path_count, exp_cnt);
               chk("done_overflow", stack_overflow, exp_ovf);
               chk("done_busy", busy, 0);
`ifdef PATH_COUNTER_STATS_EN
               chk("done_query_count", query_count, exp_nq);
               chk("done_max_level", max_stack_level, exp_max);
`endif
            end
         end
      end
   end

   task automatic pulse_start(input int s, input int t);
      @(posedge clk); #1;
      start = 1'b1;
      start_node = NODE_W'(s);
      target_node = NODE_W'(t);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Run one walk to completion; poke re-pulses start mid-walk with other nodes
   task automatic run_walk(input string nm, input int s, input int t, input bit poke,
                           output int cycles);
      armed = 0;
      model_walk(s, t);
      nq_seen = 0;
      pulse_start(s, t);
      armed = 1;
      cycles = 1;
      while (!done && cycles < 20000) begin
         @(posedge clk); #1;
         if (poke && cycles == 3) begin
            start = 1'b1;
            start_node = NODE_W'(t);
            target_node = NODE_W'(s);
         end else begin
            start = 1'b0;
         end
         cycles++;
      end
      start = 1'b0;
      chk({nm, "_done"}, done, 1);
      chk({nm, "_query_total"}, nq_seen, exp_nq);
      repeat (2) @(posedge clk);
      #1;
      chk({nm, "_done_held"}, done, 1);
   endtask

   initial begin
      int cyc;
      int s, t;
      rst_n = 1'b1;
      start = 1'b0;
      start_node = '0;
      target_node = '0;
      #3 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Diamond, randomized handshake timing
      diamond();
      run_walk("diamond", 0, 3, 0, cyc);
      chk("diamond_count", path_count, 2);
      chk("diamond_queries", nq_seen, 3);
      chk("diamond_overflow", stack_overflow, 0);

      // Start equals target: counted without any query
      run_walk("same_node", 5, 5, 0, cyc);
      chk("same_node_count", path_count, 1);
      chk("same_node_queries", nq_seen, 0);
      chk("same_node_latency_le4", (cyc <= 4), 1);

      // Isolated start node: single no-edges beat ends the reply
      clear_graph();
      run_walk("no_edges", 7, 3, 0, cyc);
      chk("no_edges_count", path_count, 0);
      chk("no_edges_queries", nq_seen, 1);

      // Stalled query handshake and gapped reply beats
      diamond();
      stall_mode = 1;
      run_walk("stall", 0, 3, 0, cyc);
      chk("stall_count", path_count, 2);
      stall_mode = 0;

      // Fan-out wider than the stack
      clear_graph();
      for (int k = 1; k <= 6; k++) adj[0].push_back(k);
      run_walk("overflow", 0, 9, 0, cyc);
      chk("overflow_flag", stack_overflow, 1);
      chk("overflow_count", path_count, 0);

      // start while busy is ignored
      diamond();
      run_walk("busy_start", 0, 3, 1, cyc);
      chk("busy_start_count", path_count, 2);

      // Reset in the middle of a reply, then a clean rerun
      diamond();
      armed = 0;
      model_walk(0, 3);
      pulse_start(0, 3);
      cyc = 0;
      while (!bus.reply_ready && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("reached_recv", bus.reply_ready, 1);
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      exp_q.delete();
      run_walk("after_reset", 0, 3, 0, cyc);
      chk("after_reset_count", path_count, 2);

      // Random DAGs: edges only to higher ids keep the graph acyclic
      for (int it = 0; it < 20; it++) begin
         do begin
            clear_graph();
            for (int i = 0; i < 9; i++) begin
               int deg;
               deg = $urandom_range(0, 2);
               for (int k = 0; k < deg; k++) adj[i].push_back($urandom_range(i + 1, 9));
            end
            s = $urandom_range(0, 3);
            t = $urandom_range(s, 9);
            model_walk(s, t);
         end while (exp_nq > 200);
         run_walk("random", s, t, 0, cyc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
